// File: rtl/rgbw_pkg.sv
// Shared RGBW link definitions: frame constants, SPI byte geometry and rx FSM states.
package rgbw_pkg;

  localparam logic [7:0]  RGBW_SYNC_BYTE = 8'h55;
  localparam int unsigned RGBW_FRAME_LEN = 8;

  localparam int unsigned SPI_BYTE_W = 8;
  localparam int unsigned SPI_CNT_W  = $clog2(SPI_BYTE_W);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } rx_state_e;

endpackage

// File: rtl/rgbw_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, plus one history flop for
// single-cycle rise/fall pulses. IDLE_VAL is the level the chain resets to.
module rgbw_sync_edge #(
  parameter int unsigned STAGES   = 2,
  parameter logic        IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{IDLE_VAL}};
      hist_q <= IDLE_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise_c = sync_q[STAGES-1] & ~hist_q;
  assign fall_c = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/rgbw_spi_byte_rx.sv
// SPI mode-0 slave byte receiver oversampled on clk. Presents each byte with a
// stretched rdy level and echoes the previous byte on MISO.
module rgbw_spi_byte_rx
  import rgbw_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RDY_HOLD    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [SPI_BYTE_W-1:0] rx_byte,
  output logic                  rdy,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int unsigned HOLD_W = $clog2(RDY_HOLD + 1);

  logic [1:0]             rst_sync_q;
  logic                   rst_n;
  logic                   sck_rise_c, sck_fall_c, cs_rise_c, cs_fall_c;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_c;

  rx_state_e              state_q, state_nxt;
  logic                   start_c, stop_c, rx_edge_c, tx_edge_c, done_c;
  logic [SPI_CNT_W-1:0]   bit_cnt_q;
  logic [SPI_BYTE_W-1:0]  rx_shift_q, tx_shift_q, echo_q, rx_next_c;
  logic                   done_q;
  logic [HOLD_W-1:0]      hold_q;

  // Reset asserts asynchronously, releases on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  rgbw_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .din(spi_sck), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
  );

  rgbw_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(spi_cs_n), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
  );

  // Same depth as the sck chain so mosi is sampled alongside the sck level that made the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_c = mosi_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // cs_n rise takes priority over any sck edge in the same cycle.
  always_comb begin
    state_nxt = state_q;
    start_c   = 1'b0;
    stop_c    = 1'b0;
    rx_edge_c = 1'b0;
    tx_edge_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall_c) begin
          state_nxt = ACTIVE;
          start_c   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise_c) begin
          state_nxt = IDLE;
          stop_c    = 1'b1;
        end else begin
          rx_edge_c = sck_rise_c;
          tx_edge_c = sck_fall_c;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_next_c = {rx_shift_q[SPI_BYTE_W-2:0], mosi_c};
  assign done_c    = rx_edge_c && (bit_cnt_q == SPI_CNT_W'(SPI_BYTE_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      echo_q      <= '0;
      rx_byte     <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      frame_err   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      done_q    <= 1'b0;
      if (start_c) begin
        bit_cnt_q   <= '0;
        tx_shift_q  <= echo_q;
        spi_miso    <= echo_q[SPI_BYTE_W-1];
        spi_miso_oe <= 1'b1;
      end
      if (stop_c) begin
        bit_cnt_q   <= '0;
        rx_shift_q  <= '0;
        frame_err   <= (bit_cnt_q != '0);
        spi_miso_oe <= 1'b0;
      end
      if (rx_edge_c) begin
        rx_shift_q <= rx_next_c;
        if (done_c) begin
          bit_cnt_q <= '0;
          rx_byte   <= rx_next_c;
          echo_q    <= rx_next_c;
          done_q    <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + SPI_CNT_W'(1);
        end
      end
      if (tx_edge_c) begin
        tx_shift_q <= {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
        spi_miso   <= tx_shift_q[SPI_BYTE_W-2];
      end
    end
  end

  // rdy hold: loaded one cycle after completion, counts down to a saturated zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      rdy     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (done_q) begin
        hold_q <= HOLD_W'(RDY_HOLD - 1);
        rdy    <= 1'b1;
        if (rdy) overrun <= 1'b1;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - HOLD_W'(1);
      end else begin
        rdy <= 1'b0;
      end
      if (stop_c) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rgbw_spi_byte_rx.sv
// Directed bench for rgbw_spi_byte_rx: reset, single byte, full frame with MISO echo,
// framing error, overrun at clk/2, and reset mid-byte / mid-rdy.
module tb_rgbw_spi_byte_rx;
  import rgbw_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, rdy, overrun, frame_err;
  logic [7:0] rx_byte;
  logic       o_miso, o_miso_oe, o_rdy, o_overrun, o_frame_err;
  logic [7:0] o_rx_byte;

  int unsigned n_cmp = 0, n_err = 0;

  rgbw_spi_byte_rx u_dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .rx_byte(rx_byte), .rdy(rdy),
    .overrun(overrun), .frame_err(frame_err)
  );

  // A clk/2 byte takes 16 clk, so a hold longer than that is needed to see overrun.
  rgbw_spi_byte_rx #(.SYNC_STAGES(2), .RDY_HOLD(24)) u_ovr (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(o_miso), .spi_miso_oe(o_miso_oe), .rx_byte(o_rx_byte), .rdy(o_rdy),
    .overrun(o_overrun), .frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned rdy_rises = 0, o_rises = 0, run = 0, last_run = 0, gap = 0, min_gap = 1000;
  int unsigned rise_cyc = 0, fe_pulses = 0, fe_cycles = 0, t8 = 0;
  logic        rdy_p = 1'b0, o_rdy_p = 1'b0, fe_p = 1'b0, seen_fall = 1'b0;
  logic [7:0]  rx_log[$];

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rdy) begin
      if (!rdy_p) begin
        rdy_rises++;
        rise_cyc = cyc;
        run = 0;
        rx_log.push_back(rx_byte);
        if (seen_fall && gap < min_gap) min_gap = gap;
      end
      run++;
    end else begin
      if (rdy_p) begin
        last_run = run;
        gap = 0;
        seen_fall = 1'b1;
      end
      gap++;
    end
    if (o_rdy && !o_rdy_p) o_rises++;
    if (frame_err) begin
      fe_cycles++;
      if (!fe_p) fe_pulses++;
    end
    rdy_p   = rdy;
    o_rdy_p = o_rdy;
    fe_p    = frame_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mode-0 master: mosi set while sck low, MISO captured just before each rise.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input int half,
                          output logic [7:0] cap);
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (half) @(negedge clk);
      cap = {cap[6:0], spi_miso};
      spi_sck = 1'b1;
      t8 = cyc;
      repeat (half) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  logic [7:0]  frame[8];
  logic [7:0]  cap;
  int unsigned r0, fe0, fc0, o0, base;

  initial begin
    frame = '{RGBW_SYNC_BYTE, 8'h80, 8'h03, 8'hFF, 8'h10, 8'h20, 8'h40, 8'h02};

    // 1: reset held while inputs toggle, then release.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      spi_sck  = ~spi_sck;
      spi_cs_n = ~spi_cs_n;
      @(negedge clk);
    end
    check_eq("t1_in_reset", {rx_byte, rdy, overrun, frame_err, spi_miso, spi_miso_oe}, 0);
    spi_sck = 1'b0; spi_cs_n = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("t1_after_rel", {rx_byte, rdy, overrun, frame_err, spi_miso, spi_miso_oe}, 0);

    // 2: single byte at clk/8.
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t2_oe", spi_miso_oe, 1);
    r0 = rdy_rises; fe0 = fe_pulses;
    spi_xfer(RGBW_SYNC_BYTE, 8, 4, cap);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("t2_rx", rx_byte, 8'h55);
    check_eq("t2_rdy_cnt", rdy_rises - r0, 1);
    check_eq("t2_rdy_width", last_run, 4);
    check_eq("t2_latency", rise_cyc - t8, 4);
    check_eq("t2_fe", fe_pulses - fe0, 0);
    check_eq("t2_oe_off", spi_miso_oe, 0);

    // 3: full frame in one window, then a second window reads the echo.
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    r0 = rdy_rises; base = rx_log.size(); min_gap = 1000; seen_fall = 1'b0;
    for (int i = 0; i < RGBW_FRAME_LEN; i++) spi_xfer(frame[i], 8, 4, cap);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("t3_rdy_cnt", rdy_rises - r0, RGBW_FRAME_LEN);
    for (int i = 0; i < RGBW_FRAME_LEN; i++)
      check_eq($sformatf("t3_byte%0d", i), rx_log[base+i], frame[i]);
    check_eq("t3_gap", min_gap >= 1, 1);
    check_eq("t3_width", last_run, 4);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_xfer(8'h00, 8, 4, cap);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("t3_miso_echo", cap, 8'h02);
    check_eq("t3_rx2", rx_byte, 8'h00);

    // 4: cs_n rises after 5 bits of 0xA0.
    r0 = rdy_rises; fe0 = fe_pulses; fc0 = fe_cycles;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_xfer(8'hA0, 5, 4, cap);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("t4_fe_pulses", fe_pulses - fe0, 1);
    check_eq("t4_fe_cycles", fe_cycles - fc0, 1);
    check_eq("t4_no_rdy", rdy_rises - r0, 0);
    check_eq("t4_rx_keep", rx_byte, 8'h00);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_xfer(8'h3C, 8, 4, cap);
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("t4_rx_next", rx_byte, 8'h3C);
    check_eq("t4_fe_once", fe_pulses - fe0, 1);

    // 5: back-to-back bytes at clk/2.
    o0 = o_rises;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_xfer(8'h11, 8, 1, cap);
    spi_xfer(8'h22, 8, 1, cap);
    repeat (5) @(negedge clk);
    check_eq("t5_ovr", o_overrun, 1);
    check_eq("t5_ovr_rx", o_rx_byte, 8'h22);
    check_eq("t5_ovr_rdy_once", o_rises - o0, 1);
    check_eq("t5_dut_rx", rx_byte, 8'h22);
    check_eq("t5_dut_no_ovr", overrun, 0);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("t5_ovr_clr", o_overrun, 0);
    repeat (30) @(negedge clk);

    // 6: reset mid-rdy, then mid-byte; then a clean byte.
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_xfer(8'h5A, 8, 4, cap);
    @(negedge clk);
    check_eq("t6_rdy_pre", rdy, 1);
    reset = 1'b0;
    #1;
    check_eq("t6_rst_rdy", {rx_byte, rdy, overrun, spi_miso, spi_miso_oe}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("t6_oe_back", spi_miso_oe, 1);
    spi_xfer(8'hF0, 4, 4, cap);
    reset = 1'b0;
    #1;
    check_eq("t6_rst_byte", {rx_byte, rdy, spi_miso_oe}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    r0 = rdy_rises; fe0 = fe_pulses;
    spi_xfer(8'hC3, 8, 4, cap);
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("t6_rx_clean", rx_byte, 8'hC3);
    check_eq("t6_rdy_once", rdy_rises - r0, 1);
    check_eq("t6_no_fe", fe_pulses - fe0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
